// File: rtl/pes_ram_pkg.sv
// Shared types and helpers for the pes_dpram_ctrl dual-port RAM slice.
// Parity storage is enabled by defining PES_RAM_PARITY_EN.
package pes_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    // Even parity bit: the XOR of all data bits, so that data plus parity has an even number of ones.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/pes_dpram_ctrl_if.sv
// Port A/B access bus and status outputs of pes_dpram_ctrl.
// The master modport is the user side and the slave modport is the RAM.
interface pes_dpram_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic                  en_a;
    logic                  we_a;
    logic [ADDR_W-1:0]     addr_a;
    logic [DATA_W-1:0]     din_a;
    logic [DATA_W-1:0]     q_a;
    logic                  en_b;
    logic                  we_b;
    logic [ADDR_W-1:0]     addr_b;
    logic [DATA_W-1:0]     din_b;
    logic [DATA_W-1:0]     q_b;
    logic                  busy;
    logic                  collision;
    logic [1:0]            oob;
    logic [1:0]            perr;
    logic [2*DATA_W-1:0]   oeb;

    modport master (
        output en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b,
        input  q_a, q_b, busy, collision, oob, perr, oeb
    );

    modport slave (
        input  en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b,
        output q_a, q_b, busy, collision, oob, perr, oeb
    );
endinterface

// File: rtl/pes_ram_clear_seq.sv
// Post-reset clearing sequencer: it walks every address once and then enters READY.
// busy stays high from reset until the last word has been written.
module pes_ram_clear_seq
    import pes_ram_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              busy_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= READY;
                end
            endcase
        end
    end

    assign clr_we_o   = (state_q == CLEAR) && !rst;
    assign clr_addr_o = cnt_q;
    assign busy_o     = busy_q;

endmodule

// File: rtl/pes_dpram_ctrl.sv
// True dual-port RAM with post-reset clear, same-address collision resolution and out-of-range flags.
// Define PES_RAM_PARITY_EN to store a parity bit per word and report read parity errors on perr.
module pes_dpram_ctrl
    import pes_ram_pkg::*;
#(
    parameter int               DATA_W   = 8,
    parameter int               DEPTH    = 32,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter bit               PRIO_A   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    pes_dpram_ctrl_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
`ifdef PES_RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    function automatic logic [MEM_W-1:0] pack_word(input logic [DATA_W-1:0] data);
`ifdef PES_RAM_PARITY_EN
        return {even_parity(32'(data)), data};
`else
        return data;
`endif
    endfunction

    logic [MEM_W-1:0]  mem_q [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              busy;

    pes_ram_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (busy)
    );

    logic              ready;
    logic              in_rng_a, in_rng_b;
    logic              oob_a, oob_b;
    logic              acc_a, acc_b;
    logic              wr_a, wr_b;
    logic              same_addr, coll;
    logic              mem_we_a, mem_we_b;
    logic [DATA_W-1:0] coll_din;
    logic [MEM_W-1:0]  rd_a, rd_b;

    // A port access that coincides with rst is dropped, just like accesses issued during the clear.
    assign ready     = !busy && !rst;
    assign in_rng_a  = 32'(bus.addr_a) < DEPTH;
    assign in_rng_b  = 32'(bus.addr_b) < DEPTH;
    assign oob_a     = ready && bus.en_a && !in_rng_a;
    assign oob_b     = ready && bus.en_b && !in_rng_b;
    assign acc_a     = ready && bus.en_a && in_rng_a;
    assign acc_b     = ready && bus.en_b && in_rng_b;
    assign wr_a      = acc_a && bus.we_a;
    assign wr_b      = acc_b && bus.we_b;
    assign same_addr = acc_a && acc_b && (bus.addr_a == bus.addr_b);
    assign coll      = same_addr && (wr_a || wr_b);
    assign mem_we_a  = wr_a && !(same_addr && wr_b && !PRIO_A);
    assign mem_we_b  = wr_b && !(same_addr && wr_a && PRIO_A);
    assign coll_din  = (wr_a && (!wr_b || PRIO_A)) ? bus.din_a : bus.din_b;
    assign rd_a      = mem_q[bus.addr_a];
    assign rd_b      = mem_q[bus.addr_b];

    // NOTE: the array has no reset; the clear sequencer initialises it, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (clr_we)   mem_q[clr_addr]   <= pack_word(INIT_VAL);
        if (mem_we_a) mem_q[bus.addr_a] <= pack_word(bus.din_a);
        if (mem_we_b) mem_q[bus.addr_b] <= pack_word(bus.din_b);
    end

    logic [DATA_W-1:0] q_a_q, q_a_d, q_b_q, q_b_d;
    logic              coll_q;
    logic [1:0]        oob_q;

    // NOTE: every output gets a default first, so idle or disabled ports hold their value without inferring a latch.
    always_comb begin
        q_a_d = q_a_q;
        q_b_d = q_b_q;
        if (oob_a)          q_a_d = '0;
        else if (coll)      q_a_d = coll_din;
        else if (wr_a)      q_a_d = bus.din_a;
        else if (acc_a)     q_a_d = rd_a[DATA_W-1:0];
        if (oob_b)          q_b_d = '0;
        else if (coll)      q_b_d = coll_din;
        else if (wr_b)      q_b_d = bus.din_b;
        else if (acc_b)     q_b_d = rd_b[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_a_q  <= '0;
            q_b_q  <= '0;
            coll_q <= 1'b0;
            oob_q  <= 2'b00;
        end else begin
            q_a_q  <= q_a_d;
            q_b_q  <= q_b_d;
            coll_q <= coll;
            oob_q  <= {oob_b, oob_a};
        end
    end

`ifdef PES_RAM_PARITY_EN
    logic [1:0] perr_q, perr_d;

    // A read reports a stored-versus-recomputed mismatch; writes, write-through and oob accesses clear the flag.
    always_comb begin
        perr_d = perr_q;
        if (oob_a || wr_a || (acc_a && coll))
            perr_d[PORT_A] = 1'b0;
        else if (acc_a)
            perr_d[PORT_A] = even_parity(32'(rd_a[DATA_W-1:0])) != rd_a[DATA_W];
        if (oob_b || wr_b || (acc_b && coll))
            perr_d[PORT_B] = 1'b0;
        else if (acc_b)
            perr_d[PORT_B] = even_parity(32'(rd_b[DATA_W-1:0])) != rd_b[DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) perr_q <= 2'b00;
        else     perr_q <= perr_d;
    end

    assign bus.perr = perr_q;
`else
    assign bus.perr = 2'b00;
`endif

    assign bus.q_a       = q_a_q;
    assign bus.q_b       = q_b_q;
    assign bus.busy      = busy;
    assign bus.collision = coll_q;
    assign bus.oob       = oob_q;
    assign bus.oeb       = {(2*DATA_W){busy}};

endmodule

// File: tb/tb_pes_dpram_ctrl.sv
// Scoreboard bench for pes_dpram_ctrl: two instances (DEPTH 32/PRIO_A 1 and DEPTH 20/PRIO_A 0) share the
// same stimulus and are checked every cycle against a word-level reference model; PES_RAM_PARITY_EN adds a parity-error case.
module tb_pes_dpram_ctrl;

    typedef struct packed {
        logic [7:0]  q_a;
        logic [7:0]  q_b;
        logic        busy;
        logic        coll;
        logic [1:0]  oob;
        logic [1:0]  perr;
        logic [15:0] oeb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pes_dpram_ctrl_if #(.DATA_W(8), .ADDR_W(5)) bus0 ();
    pes_dpram_ctrl_if #(.DATA_W(8), .ADDR_W(5)) bus1 ();

    assign bus1.en_a   = bus0.en_a;
    assign bus1.we_a   = bus0.we_a;
    assign bus1.addr_a = bus0.addr_a;
    assign bus1.din_a  = bus0.din_a;
    assign bus1.en_b   = bus0.en_b;
    assign bus1.we_b   = bus0.we_b;
    assign bus1.addr_b = bus0.addr_b;
    assign bus1.din_b  = bus0.din_b;

    pes_dpram_ctrl #(.DATA_W(8), .DEPTH(32), .INIT_VAL(8'h00), .PRIO_A(1'b1)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    pes_dpram_ctrl #(.DATA_W(8), .DEPTH(20), .INIT_VAL(8'h00), .PRIO_A(1'b0)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    int total = 0;
    int bad = 0;
    int n_pushed = 0;
    int n_popped = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    // Reference model state: word contents, corrupted-parity marks, held outputs and remaining clear cycles.
    logic [7:0] m_mem [2][32];
    logic       m_cor [2][32];
    logic [7:0] m_qa [2];
    logic [7:0] m_qb [2];
    logic       m_pa [2];
    logic       m_pb [2];
    int         m_clear_left [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_step(input int d, input logic r,
                                        input logic ea, input logic wa, input logic [4:0] aa, input logic [7:0] da,
                                        input logic eb, input logic wb, input logic [4:0] ab, input logic [7:0] db);
        exp_t e;
        int   dep = (d == 0) ? 32 : 20;
        bit   prio_a = (d == 0);
        logic oa, ob, va, vb, same, xa, xb;
        e.coll = 1'b0;
        e.oob  = 2'b00;
        if (r) begin
            m_clear_left[d] = dep;
            for (int i = 0; i < 32; i++) begin
                m_mem[d][i] = 8'h00;
                m_cor[d][i] = 1'b0;
            end
            m_qa[d] = 8'h00; m_qb[d] = 8'h00; m_pa[d] = 1'b0; m_pb[d] = 1'b0;
        end else if (m_clear_left[d] > 0) begin
            m_clear_left[d]--;
        end else begin
            oa   = ea && (int'(aa) >= dep);
            ob   = eb && (int'(ab) >= dep);
            va   = ea && !oa;
            vb   = eb && !ob;
            xa   = va && wa;
            xb   = vb && wb;
            same = va && vb && (aa == ab);
            e.oob  = {ob, oa};
            e.coll = same && (xa || xb);
            if (same && xa && xb) begin
                m_mem[d][aa] = prio_a ? da : db;
                m_cor[d][aa] = 1'b0;
                m_qa[d] = m_mem[d][aa]; m_qb[d] = m_mem[d][aa];
                m_pa[d] = 1'b0;         m_pb[d] = 1'b0;
            end else begin
                if (oa)                    begin m_qa[d] = 8'h00;         m_pa[d] = 1'b0;          end
                else if (xa)               begin m_qa[d] = da;            m_pa[d] = 1'b0;          end
                else if (va && same && xb) begin m_qa[d] = db;            m_pa[d] = 1'b0;          end
                else if (va)               begin m_qa[d] = m_mem[d][aa];  m_pa[d] = m_cor[d][aa];  end
                if (ob)                    begin m_qb[d] = 8'h00;         m_pb[d] = 1'b0;          end
                else if (xb)               begin m_qb[d] = db;            m_pb[d] = 1'b0;          end
                else if (vb && same && xa) begin m_qb[d] = da;            m_pb[d] = 1'b0;          end
                else if (vb)               begin m_qb[d] = m_mem[d][ab];  m_pb[d] = m_cor[d][ab];  end
                if (xa) begin m_mem[d][aa] = da; m_cor[d][aa] = 1'b0; end
                if (xb) begin m_mem[d][ab] = db; m_cor[d][ab] = 1'b0; end
            end
        end
        e.busy = r || (m_clear_left[d] > 0);
        e.oeb  = e.busy ? 16'hFFFF : 16'h0000;
        e.q_a  = m_qa[d];
        e.q_b  = m_qb[d];
        e.perr = {m_pb[d], m_pa[d]};
        return e;
    endfunction

    // One clock of stimulus: drive after the falling edge and queue what both instances must show after the next rising edge.
    task automatic drive(input logic r,
                         input logic ea, input logic wa, input logic [4:0] aa, input logic [7:0] da,
                         input logic eb, input logic wb, input logic [4:0] ab, input logic [7:0] db);
        @(negedge clk);
        rst = r;
        bus0.en_a = ea; bus0.we_a = wa; bus0.addr_a = aa; bus0.din_a = da;
        bus0.en_b = eb; bus0.we_b = wb; bus0.addr_b = ab; bus0.din_b = db;
        sb0.push_back(model_step(0, r, ea, wa, aa, da, eb, wb, ab, db));
        sb1.push_back(model_step(1, r, ea, wa, aa, da, eb, wb, ab, db));
        n_pushed += 2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, 1'b0, 5'(i), 8'h00, 1'b1, 1'b0, 5'(31 - i), 8'h00);
    endtask

    task automatic random_ops(input int n, input logic with_rst);
        logic [4:0] aa, ab;
        for (int i = 0; i < n; i++) begin
            aa = 5'($urandom_range(0, 31));
            ab = ($urandom_range(0, 2) == 0) ? aa : 5'($urandom_range(0, 31));
            drive(with_rst && (i < 2),
                  1'($urandom), 1'($urandom), aa, 8'($urandom),
                  1'($urandom), 1'($urandom), ab, 8'($urandom));
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input exp_t g);
        check({tag, ".q_a"},       32'(g.q_a),  32'(e.q_a));
        check({tag, ".q_b"},       32'(g.q_b),  32'(e.q_b));
        check({tag, ".busy"},      32'(g.busy), 32'(e.busy));
        check({tag, ".collision"}, 32'(g.coll), 32'(e.coll));
        check({tag, ".oob"},       32'(g.oob),  32'(e.oob));
        check({tag, ".perr"},      32'(g.perr), 32'(e.perr));
        check({tag, ".oeb"},       32'(g.oeb),  32'(e.oeb));
    endtask

    exp_t got0, got1;

    // Monitor: one queued expectation per instance is consumed 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        got0.q_a = bus0.q_a; got0.q_b = bus0.q_b; got0.busy = bus0.busy; got0.coll = bus0.collision;
        got0.oob = bus0.oob; got0.perr = bus0.perr; got0.oeb = bus0.oeb;
        got1.q_a = bus1.q_a; got1.q_b = bus1.q_b; got1.busy = bus1.busy; got1.coll = bus1.collision;
        got1.oob = bus1.oob; got1.perr = bus1.perr; got1.oeb = bus1.oeb;
        if (sb0.size() > 0) begin
            compare("d0", sb0.pop_front(), got0);
            n_popped++;
        end
        if (sb1.size() > 0) begin
            compare("d1", sb1.pop_front(), got1);
            n_popped++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus0.en_a = 1'b0; bus0.we_a = 1'b0; bus0.addr_a = '0; bus0.din_a = '0;
        bus0.en_b = 1'b0; bus0.we_b = 1'b0; bus0.addr_b = '0; bus0.din_b = '0;

        // Reset for 3 cycles, then the full clear, then read back every address.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
        idle(34);
        read_all();

        // Write-first on A, then read the same word on B.
        drive(1'b0, 1'b1, 1'b1, 5'd5, 8'hA5, 1'b0, 1'b0, 5'd0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd5, 8'h00);

        // Same-address double write, then read back on both ports.
        drive(1'b0, 1'b1, 1'b1, 5'd9, 8'h11, 1'b1, 1'b1, 5'd9, 8'h22);
        drive(1'b0, 1'b1, 1'b0, 5'd9, 8'h00, 1'b1, 1'b0, 5'd9, 8'h00);

        // Write-through in both directions and a same-address double read.
        drive(1'b0, 1'b1, 1'b1, 5'd7, 8'h3C, 1'b1, 1'b0, 5'd7, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 5'd7, 8'h00, 1'b1, 1'b1, 5'd7, 8'hC3);
        drive(1'b0, 1'b1, 1'b0, 5'd7, 8'h00, 1'b1, 1'b0, 5'd7, 8'h00);

        // Out-of-range on the DEPTH=20 instance: single and double, then hold and full readback.
        drive(1'b0, 1'b1, 1'b1, 5'd25, 8'hFF, 1'b0, 1'b0, 5'd0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 5'd31, 8'h00, 1'b1, 1'b1, 5'd20, 8'h77);
        drive(1'b0, 1'b1, 1'b0, 5'd19, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00);
        idle(2);
        read_all();

        random_ops(300, 1'b0);

        // Reset in the middle of traffic with random inputs through reset and clear.
        random_ops(34, 1'b1);
        read_all();

`ifdef PES_RAM_PARITY_EN
        drive(1'b0, 1'b1, 1'b1, 5'd3, 8'h42, 1'b0, 1'b0, 5'd0, 8'h00);
        idle(1);
        u_dut0.mem_q[3][8] = ~u_dut0.mem_q[3][8];
        m_cor[0][3] = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b1, 1'b0, 5'd3, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 5'd3, 8'h24, 1'b0, 1'b0, 5'd0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
`endif

        idle(2);
        @(posedge clk);
        #2;
        check("sb_drained", 32'(sb0.size() + sb1.size()), 32'd0);
        check("entries_compared", 32'(n_popped), 32'(n_pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
